mdu_unit: RTL and testbench

Multiply/divide unit for the pipelined MIPS32 core, sitting in the EX stage beside the ALU and consuming forwarded operands. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and MTHI/MTLO in one cycle. It holds the architectural HI/LO registers read by MFHI/MFLO. It exports `busy` so the hazard unit can stall any later multiply/divide or HI/LO instruction in ID.

---
 rtl/mdu_unit.sv | 162 ++++++++++++++++
 tb/tb_mdu_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: MIPS32 EX-stage multiply/divide unit holding the architectural HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency.
// Executes MTHI/MTLO in a single cycle.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous, active-low
//   start  - launch the operation in op this cycle
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b   - rs / rt operands (forwarded)
//   busy   - multi-cycle operation in flight (state only, no path from start)
//   hi, lo - architectural HI / LO registers

module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // The counter only ever holds latency-1, so clog2(latency) bits are enough.
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_run  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    // Result datapath; the result is computed at the accepting edge and held until completion.
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] uq_mag, ur_mag;
    logic [31:0] sdiv_q, sdiv_r;
    logic [31:0] udiv_q, udiv_r;

    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide via magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned,
        // which makes 0x80000000 / -1 yield 0x80000000 rem 0 without special-casing.
        a_neg  = a[31];
        b_neg  = b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        uq_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        ur_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
        sdiv_q = (a_neg ^ b_neg) ? (32'd0 - uq_mag) : uq_mag;
        sdiv_r = a_neg ? (32'd0 - ur_mag) : ur_mag;

        udiv_q = (b == 32'd0) ? 32'd0 : (a / b);
        udiv_r = (b == 32'd0) ? 32'd0 : (a % b);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            st_idle: begin
                if (start) begin
                    case (op)
                        3'd0: begin
                            state_d   = st_run;
                            cnt_d     = MULT_LOAD;
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                        end
                        3'd1: begin
                            state_d   = st_run;
                            cnt_d     = MULT_LOAD;
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                        end
                        3'd2: begin
                            state_d   = st_run;
                            cnt_d     = DIV_LOAD;
                            pend_hi_d = sdiv_r;
                            pend_lo_d = sdiv_q;
                            // Divide by zero runs full latency but leaves HI/LO untouched.
                            pend_wr_d = (b != 32'd0);
                        end
                        3'd3: begin
                            state_d   = st_run;
                            cnt_d     = DIV_LOAD;
                            pend_hi_d = udiv_r;
                            pend_lo_d = udiv_q;
                            pend_wr_d = (b != 32'd0);
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            default: begin
                // start is ignored while running.
                if (cnt_q == '0) begin
                    state_d   = st_idle;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= st_idle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == st_run);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit.
// Directed sequence followed by random back-to-back ops.
// Results are checked against a 64-bit arithmetic model of HI/LO.

module tb_mdu_unit;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    mdu_unit #(
        .MULT_CYCLES(MULT_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, ref_hi);
        chk({tag, "_lo"}, lo, ref_lo);
    endtask

    // Architectural effect of one accepted op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin
                p = sx * sy;
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            3'd1: begin
                pu = ux * uy;
                ref_hi = pu[63:32];
                ref_lo = pu[31:0];
            end
            3'd2: if (y != 32'd0) begin
                ref_lo = 32'(sx / sy);
                ref_hi = 32'(sx % sy);
            end
            3'd3: if (y != 32'd0) begin
                ref_lo = 32'(ux / uy);
                ref_hi = 32'(ux % uy);
            end
            3'd4: ref_hi = x;
            3'd5: ref_lo = x;
            default: ;
        endcase
    endtask

    // Launch an op at the next edge, check busy and HI/LO hold every busy cycle, then the result.
    // With inject set, random starts are driven throughout the busy window and must be ignored.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inject);
        int          lat;
        logic [31:0] old_hi, old_lo;
        old_hi = ref_hi;
        old_lo = ref_lo;
        lat    = (o <= 3'd1) ? int'(MULT_LAT) : (o <= 3'd3) ? int'(DIV_LAT) : 0;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        step();
        start  = 1'b0;
        model(o, x, y);
        for (int i = 0; i < lat; i++) begin
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_hi_hold", hi, old_hi);
            chk("run_lo_hold", lo, old_lo);
            if (inject) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
                a     = $urandom;
                b     = $urandom;
            end
            step();
            start = 1'b0;
        end
        chk_idle("done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ref_hi   = 32'd0;
        ref_lo   = 32'd0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        a        = 32'd0;
        b        = 32'd0;

        step();
        step();
        chk_idle("reset");
        reset = 1'b1;

        // Multiply
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // Divide, including the overflow corner
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        // Divide by zero leaves preloaded HI/LO
        run_op(3'd4, 32'h1111_1111, 32'd0, 1'b0);
        run_op(3'd5, 32'h2222_2222, 32'd0, 1'b0);
        run_op(3'd2, 32'd55, 32'd0, 1'b0);
        chk("div0_hi", hi, 32'h1111_1111);
        chk("div0_lo", lo, 32'h2222_2222);
        run_op(3'd3, 32'd55, 32'd0, 1'b0);
        chk("divu0_lo", lo, 32'h2222_2222);

        // No-op opcodes
        run_op(3'd6, 32'hABCD_0000, 32'd1, 1'b0);
        run_op(3'd7, 32'hABCD_0000, 32'd1, 1'b0);

        // Start while busy is ignored
        run_op(3'd0, 32'd3, 32'd4, 1'b1);
        chk("ignore_hi", hi, 32'd0);
        chk("ignore_lo", lo, 32'd12);

        // Back-to-back
        run_op(3'd0, 32'd2, 32'd3, 1'b0);
        chk("b2b_lo1", lo, 32'd6);
        run_op(3'd3, 32'd100, 32'd7, 1'b0);
        chk("b2b_lo2", lo, 32'd14);
        chk("b2b_hi2", hi, 32'd2);

        // Reset mid-op aborts, and no late write follows
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd100;
        b     = 32'd10;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_busy", {31'd0, busy}, 32'd1);
            step();
        end
        reset = 1'b0;
        step();
        reset  = 1'b1;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        chk_idle("abort");
        for (int i = 0; i < int'(DIV_LAT) + 2; i++) begin
            step();
            chk_idle("abort_late");
        end

        // Reset wins over a simultaneous start
        reset = 1'b0;
        start = 1'b1;
        op    = 3'd4;
        a     = 32'h5555_5555;
        step();
        start = 1'b0;
        reset = 1'b1;
        chk_idle("rst_start");
        start = 1'b1;
        op    = 3'd0;
        reset = 1'b0;
        step();
        start = 1'b0;
        reset = 1'b1;
        chk_idle("rst_start_mult");

        // Random back-to-back ops, with occasional zero divisors and sign corners
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
